// File: rtl/adat_decoder.sv
// ADAT receiver: recovers bit timing from NRZI run lengths, finds the 10-zero
// sync and unpacks 8 x 24-bit samples plus 4 user bits once per frame.
module adat_decoder #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned SAMPLE_RATE    = 48000,
  parameter int unsigned CLOCKS_PER_BIT = CLK_FREQ / (SAMPLE_RATE * 256),
  parameter int unsigned TIMEOUT_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adat_in,
  output logic [23:0] audio_out [0:7],
  output logic [3:0]  user_out,
  output logic        smux2_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        locked
);

  localparam int unsigned FRAME_BITS = 245;
  localparam int unsigned RUN_MAX    = TIMEOUT_BITS * CLOCKS_PER_BIT;
  localparam int unsigned HALF_BIT   = CLOCKS_PER_BIT / 2;
  localparam int unsigned CW         = $clog2(RUN_MAX + 1);
  localparam int unsigned N_MAX      = (RUN_MAX + HALF_BIT) / CLOCKS_PER_BIT;
  localparam int unsigned NW         = ($clog2(N_MAX + 1) > 4) ? $clog2(N_MAX + 1) : 4;
  localparam logic [CW-1:0] RUN_MAX_C = CW'(RUN_MAX);

  typedef enum logic [1:0] {HUNT, DATA, SYNC_WAIT} state_t;

  logic          sync1, sync2, dly;
  logic          edge_det;
  logic [CW-1:0] run_cnt;
  logic          measuring;
  logic          run_valid;
  logic          run_timeout;
  logic [NW-1:0] run_n;

  state_t                state;
  logic [7:0]            bit_cnt;
  logic [2:0]            phase;
  logic [FRAME_BITS-1:0] shreg;

  logic [FRAME_BITS-1:0] shreg_next;
  logic [8:0]            bit_next;
  logic [5:0]            phase_sum;
  logic [2:0]            phase_next;
  logic                  is_sync;
  logic                  run_bad;
  logic [23:0]           dec_audio [0:7];

  assign edge_det = sync2 ^ dly;

  // run_cnt holds the cycles since the previous edge, so in an edge cycle it is L.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      dly         <= 1'b0;
      run_cnt     <= '0;
      measuring   <= 1'b0;
      run_valid   <= 1'b0;
      run_timeout <= 1'b0;
      run_n       <= '0;
    end else begin
      sync1       <= adat_in;
      sync2       <= sync1;
      dly         <= sync2;
      run_valid   <= 1'b0;
      run_timeout <= 1'b0;
      if (edge_det) begin
        run_cnt   <= CW'(1);
        measuring <= 1'b1;
        run_valid <= measuring;
        run_n     <= NW'((32'(run_cnt) + HALF_BIT) / CLOCKS_PER_BIT);
      end else if (measuring) begin
        if (run_cnt == RUN_MAX_C) begin
          run_timeout <= 1'b1;
          measuring   <= 1'b0;
        end else begin
          run_cnt <= run_cnt + CW'(1);
        end
      end
    end
  end

  // Separators sit at every bit index with index % 5 == 4; phase tracks that
  // modulus, so a run is legal only if its zeros stop short of the next separator.
  always_comb begin
    is_sync    = (run_n == NW'(11));
    bit_next   = 9'(bit_cnt) + 9'(run_n);
    shreg_next = (shreg << run_n) | FRAME_BITS'(1);
    phase_sum  = 6'(phase) + 6'(run_n);
    phase_next = (phase_sum == 6'd5) ? 3'd0 : phase_sum[2:0];
    run_bad    = (run_n == '0) || (run_n > NW'(5)) || (phase_sum >= 6'd6) ||
                 (bit_next > 9'(FRAME_BITS));
    for (int unsigned c = 0; c < 8; c++) begin
      dec_audio[c] = '0;
      for (int unsigned g = 0; g < 6; g++) begin
        dec_audio[c][23 - 4*g -: 4] = shreg_next[FRAME_BITS - 6 - 30*c - 5*g -: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      bit_cnt     <= '0;
      phase       <= '0;
      shreg       <= '0;
      user_out    <= '0;
      smux2_out   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      locked      <= 1'b0;
      for (int unsigned c = 0; c < 8; c++) audio_out[c] <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (run_timeout) begin
        locked <= 1'b0;
        state  <= HUNT;
      end else if (run_valid) begin
        case (state)
          HUNT: begin
            if (is_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
              phase   <= '0;
            end
          end
          DATA: begin
            if (run_bad) begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              if (is_sync) begin
                state   <= DATA;
                bit_cnt <= '0;
                phase   <= '0;
              end else begin
                state <= HUNT;
              end
            end else begin
              shreg   <= shreg_next;
              bit_cnt <= bit_next[7:0];
              phase   <= phase_next;
              if (bit_next == 9'(FRAME_BITS)) begin
                for (int unsigned c = 0; c < 8; c++) audio_out[c] <= dec_audio[c];
                user_out    <= shreg_next[FRAME_BITS-1 -: 4];
                smux2_out   <= shreg_next[FRAME_BITS-2];
                frame_valid <= 1'b1;
                locked      <= 1'b1;
                state       <= SYNC_WAIT;
              end
            end
          end
          SYNC_WAIT: begin
            if (is_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
              phase   <= '0;
            end else begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              state     <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adat_decoder.sv
// Directed bench for adat_decoder: frames built bit by bit, NRZI-encoded at
// 8 clocks per bit, with table-driven frame records plus timeout/reset sequences.
module tb_adat_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        adat_in;
  logic [23:0] audio_out [0:7];
  logic [3:0]  user_out;
  logic        smux2_out;
  logic        frame_valid;
  logic        frame_err;
  logic        locked;

  adat_decoder #(
    .CLK_FREQ    (100_000_000),
    .SAMPLE_RATE (48000),
    .TIMEOUT_BITS(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adat_in    (adat_in),
    .audio_out  (audio_out),
    .user_out   (user_out),
    .smux2_out  (smux2_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int fe_cnt   = 0;
  int last_tx  = 0;
  bit jit_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every frame_valid must land exactly 4 cycles after the transition of the last frame bit.
  always @(posedge clk) begin
    #2;
    if (frame_valid) begin
      fv_cnt++;
      check("frame_valid_latency", 32'(cyc - last_tx), 32'd4);
    end
    if (frame_err) fe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int unsigned d;
    d = (b && jit_en) ? $urandom_range(3, 0) : 0;
    for (int unsigned c = 0; c < 8; c++) begin
      tick();
      if (b && c == d) begin
        adat_in = ~adat_in;
        last_tx = cyc;
      end
    end
  endtask

  task automatic send_sync();
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [0:244] f);
    for (int p = 0; p < 245; p++) send_bit(f[p]);
  endtask

  function automatic logic [0:244] build_frame(input logic [0:7][23:0] a, input logic [3:0] u);
    logic [0:244] f;
    logic [23:0]  s;
    f = '0;
    for (int i = 0; i < 4; i++) f[i] = u[3-i];
    f[4] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s = a[c];
      for (int g = 0; g < 6; g++) begin
        for (int b = 0; b < 4; b++) f[5 + 30*c + 5*g + b] = s[23 - 4*g - b];
        f[5 + 30*c + 5*g + 4] = 1'b1;
      end
    end
    return f;
  endfunction

  task automatic check_outs(input logic [0:7][23:0] ea, input logic [3:0] eu, input logic el);
    for (int c = 0; c < 8; c++)
      check($sformatf("audio_out[%0d]", c), 32'(audio_out[c]), 32'(ea[c]));
    check("user_out", 32'(user_out), 32'(eu));
    check("smux2_out", 32'(smux2_out), 32'(eu[2]));
    check("locked", 32'(locked), 32'(el));
  endtask

  typedef struct {
    logic [0:7][23:0] audio;
    logic [3:0]       user;
    bit               corrupt;
    int               exp_fv;
    int               exp_fe;
    bit               exp_locked;
  } vec_t;

  vec_t             vecs [8];
  logic [0:244]     fr;
  logic [0:7][23:0] exp_audio;
  logic [0:7][23:0] aud_d, aud_b, aud_c;
  logic [3:0]       exp_user;
  int               fv0, fe0, t0;

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].corrupt    = 1'b0;
      vecs[i].exp_fv     = 1;
      vecs[i].exp_fe     = 0;
      vecs[i].exp_locked = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      vecs[0].audio[k] = 24'(24'h123450 + k);
      vecs[1].audio[k] = 24'(24'h123450 + k);
      vecs[2].audio[k] = 24'(24'h123450 + k);
      vecs[3].audio[k] = 24'h000000;
      vecs[4].audio[k] = 24'hFFFFFF;
      vecs[5].audio[k] = 24'(24'hABCDE0 + k);
      vecs[6].audio[k] = 24'h654321;
      vecs[7].audio[k] = 24'(24'h0F1E20 + 3*k);
      aud_d[k]         = 24'(24'h5A5A00 + k);
      aud_b[k]         = 24'(24'h777000 + k);
      aud_c[k]         = 24'(24'hC0FFE0 + k);
    end
    vecs[0].user = 4'hA;
    vecs[1].user = 4'hA;
    vecs[2].user = 4'hA;
    vecs[3].user = 4'h0;
    vecs[4].user = 4'hF;
    vecs[5].user = 4'h4;
    vecs[6].user = 4'h3;
    vecs[6].corrupt    = 1'b1;
    vecs[6].exp_fv     = 0;
    vecs[6].exp_fe     = 1;
    vecs[6].exp_locked = 1'b0;
    vecs[7].user = 4'h9;

    rst     = 1'b1;
    adat_in = 1'b0;
    repeat (3) tick();
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check_outs('0, 4'h0, 1'b0);
    rst = 1'b0;

    exp_audio = '0;
    exp_user  = '0;
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) begin
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      fr  = build_frame(vecs[i].audio, vecs[i].user);
      if (vecs[i].corrupt) begin
        // Clears a nibble and its separator so bits 99..105 form one 6-bit run.
        for (int p = 100; p < 105; p++) fr[p] = 1'b0;
        fr[105] = 1'b1;
      end
      send_sync();
      send_frame(fr);
      #3;
      if (vecs[i].exp_fv != 0) begin
        exp_audio = vecs[i].audio;
        exp_user  = vecs[i].user;
      end
      check($sformatf("frame%0d_valid_count", i), 32'(fv_cnt - fv0), 32'(vecs[i].exp_fv));
      check($sformatf("frame%0d_err_count", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check_outs(exp_audio, exp_user, vecs[i].exp_locked);
    end

    t0  = last_tx;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    while (cyc < t0 + 131) tick();
    check("locked_before_timeout", 32'(locked), 32'd1);
    tick();
    check("locked_after_timeout", 32'(locked), 32'd0);
    while (cyc < t0 + 1600) tick();
    check("idle_frame_valid_count", 32'(fv_cnt - fv0), 32'd0);
    check("idle_frame_err_count", 32'(fe_cnt - fe0), 32'd0);
    check_outs(exp_audio, exp_user, 1'b0);

    jit_en = 1'b1;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_bit(1'b1);
    send_sync();
    send_frame(build_frame(aud_d, 4'h6));
    #3;
    check("recover_valid_count", 32'(fv_cnt - fv0), 32'd1);
    check("recover_err_count", 32'(fe_cnt - fe0), 32'd0);
    check_outs(aud_d, 4'h6, 1'b1);

    fv0 = fv_cnt;
    fe0 = fe_cnt;
    fr  = build_frame(aud_b, 4'h1);
    send_sync();
    for (int p = 0; p < 167; p++) send_bit(fr[p]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_frame_valid", 32'(frame_valid), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check_outs('0, 4'h0, 1'b0);
    for (int p = 167; p < 245; p++) send_bit(fr[p]);
    send_sync();
    send_frame(build_frame(aud_c, 4'hB));
    #3;
    check("after_reset_valid_count", 32'(fv_cnt - fv0), 32'd1);
    check("after_reset_err_count", 32'(fe_cnt - fe0), 32'd0);
    check_outs(aud_c, 4'hB, 1'b1);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
